sram_lsu_requester: RTL and testbench

- Initiator-side bridge that drives the 32-bit SRAM controller request interface.
- Converts byte/half/word load-store requests from the single-cycle core LSU into one 32-bit controller transaction: byte-lane mask, write-data replication, read extraction and sign/zero extension.
- Sequences the one-cycle request strobe, waits for the controller ACK, and flags misaligned, illegal or timed-out accesses.
- Sits between the LSU address decode and the SRAM controller.

---
 rtl/sram_lsu_requester.sv | 191 +++++++++++++++++++
 tb/tb_sram_lsu_requester.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_lsu_requester.sv
// LSU-to-SRAM-controller bridge: turns byte/half/word loads and stores into a
// single strobed 32-bit controller access, with lane masking and load extension.
module sram_lsu_requester #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  input  logic        i_lsu_wren,
  input  logic        i_lsu_rden,
  input  logic [1:0]  i_lsu_size,
  input  logic        i_lsu_unsigned,
  output logic        o_lsu_busy,
  output logic        o_lsu_done,
  output logic        o_lsu_err,
  output logic [31:0] o_lsu_rdata,
  output logic [17:0] o_ADDR,
  output logic [31:0] o_WDATA,
  output logic [3:0]  o_BMASK,
  output logic        o_WREN,
  output logic        o_RDEN,
  input  logic [31:0] i_RDATA,
  input  logic        i_ACK
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic [1:0]  lo, lo_d;
  logic [1:0]  size, size_d;
  logic        uns, uns_d;
  logic        is_load, is_load_d;
  logic        busy_d, done_d, err_d, wren_d, rden_d;
  logic [31:0] rdata_d, wdata_d;
  logic [17:0] addr_d;
  logic [3:0]  bmask_d;
  logic        bad_req;
  logic [31:0] shifted, load_ext;

  // Upper address bits lie outside the SRAM window and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_lsu_addr[31:19];

  assign bad_req = (i_lsu_wren && i_lsu_rden) ||
                   (i_lsu_size == 2'b11) ||
                   (i_lsu_size == SZ_HALF && i_lsu_addr[0]) ||
                   (i_lsu_size == SZ_WORD && i_lsu_addr[1:0] != 2'b00);

  assign shifted = i_RDATA >> {lo, 3'b000};

  always_comb begin
    case (size)
      SZ_BYTE: load_ext = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_ext = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = i_RDATA;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    lo_d      = lo;
    size_d    = size;
    uns_d     = uns;
    is_load_d = is_load;
    done_d    = 1'b0;
    wren_d    = 1'b0;
    rden_d    = 1'b0;
    err_d     = o_lsu_err;
    rdata_d   = o_lsu_rdata;
    addr_d    = o_ADDR;
    bmask_d   = o_BMASK;
    wdata_d   = o_WDATA;

    case (state)
      S_IDLE: begin
        if (i_lsu_wren || i_lsu_rden) begin
          lo_d      = i_lsu_addr[1:0];
          size_d    = i_lsu_size;
          uns_d     = i_lsu_unsigned;
          is_load_d = i_lsu_rden;
          if (bad_req) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = S_ISSUE;
            wren_d  = i_lsu_wren;
            rden_d  = i_lsu_rden;
            addr_d  = {i_lsu_addr[18:2], 1'b0};
            case (i_lsu_size)
              SZ_BYTE: begin
                bmask_d = 4'b0001 << i_lsu_addr[1:0];
                wdata_d = {4{i_lsu_wdata[7:0]}};
              end
              SZ_HALF: begin
                bmask_d = 4'b0011 << {i_lsu_addr[1], 1'b0};
                wdata_d = {2{i_lsu_wdata[15:0]}};
              end
              default: begin
                bmask_d = 4'b1111;
                wdata_d = i_lsu_wdata;
              end
            endcase
            if (i_lsu_rden) wdata_d = 32'h0;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = 8'h0;
      end
      S_WAIT: begin
        // ACK is tested first so it wins over a coincident timeout.
        if (i_ACK) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b0;
          rdata_d = is_load ? load_ext : 32'h0;
          cnt_d   = 8'h0;
        end else if (cnt == CNT_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = 32'h0;
          cnt_d   = 8'h0;
        end else begin
          cnt_d = cnt + 8'h1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 8'h0;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    // NOTE: every register is cleared on reset, including the latched request,
    // so an abandoned access leaves nothing stale behind.
    if (!i_reset) begin
      state       <= S_IDLE;
      cnt         <= 8'h0;
      lo          <= 2'b00;
      size        <= 2'b00;
      uns         <= 1'b0;
      is_load     <= 1'b0;
      o_lsu_busy  <= 1'b0;
      o_lsu_done  <= 1'b0;
      o_lsu_err   <= 1'b0;
      o_lsu_rdata <= 32'h0;
      o_ADDR      <= 18'h0;
      o_WDATA     <= 32'h0;
      o_BMASK     <= 4'h0;
      o_WREN      <= 1'b0;
      o_RDEN      <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      lo          <= lo_d;
      size        <= size_d;
      uns         <= uns_d;
      is_load     <= is_load_d;
      o_lsu_busy  <= busy_d;
      o_lsu_done  <= done_d;
      o_lsu_err   <= err_d;
      o_lsu_rdata <= rdata_d;
      o_ADDR      <= addr_d;
      o_WDATA     <= wdata_d;
      o_BMASK     <= bmask_d;
      o_WREN      <= wren_d;
      o_RDEN      <= rden_d;
    end
  end

endmodule

// File: tb/tb_sram_lsu_requester.sv
// Directed bench for sram_lsu_requester with a 2-cycle-write / 3-cycle-read
// controller stub that can be told never to acknowledge.
module tb_sram_lsu_requester;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_wren, lsu_rden, lsu_unsigned;
  logic [1:0]  lsu_size;
  logic        lsu_busy, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic [17:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic [3:0]  sram_bmask;
  logic        sram_wren, sram_rden, sram_ack;

  int vectors = 0;
  int miscompares = 0;
  bit stuck = 1'b0;

  logic [31:0] mem [logic [17:0]];

  always #5 clk = ~clk;

  sram_lsu_requester #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_lsu_addr(lsu_addr), .i_lsu_wdata(lsu_wdata),
    .i_lsu_wren(lsu_wren), .i_lsu_rden(lsu_rden),
    .i_lsu_size(lsu_size), .i_lsu_unsigned(lsu_unsigned),
    .o_lsu_busy(lsu_busy), .o_lsu_done(lsu_done), .o_lsu_err(lsu_err),
    .o_lsu_rdata(lsu_rdata),
    .o_ADDR(sram_addr), .o_WDATA(sram_wdata), .o_BMASK(sram_bmask),
    .o_WREN(sram_wren), .o_RDEN(sram_rden),
    .i_RDATA(sram_rdata), .i_ACK(sram_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [17:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Controller stub: strobe seen in cycle 1 -> ACK in cycle 3 (write) or 4 (read).
  initial begin
    int pend;
    bit pend_rd;
    logic [17:0] pa;
    logic [31:0] w;
    pend = 0; pend_rd = 1'b0; pa = '0;
    sram_ack = 1'b0; sram_rdata = 32'h0;
    forever begin
      @(negedge clk);
      sram_ack = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            sram_ack = 1'b1;
            if (pend_rd) sram_rdata = rd_mem(pa);
          end
        end
        if (sram_wren && !stuck) begin
          w = rd_mem(sram_addr);
          for (int b = 0; b < 4; b++)
            if (sram_bmask[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
          mem[sram_addr] = w;
          pend = 2; pend_rd = 1'b0; pa = sram_addr;
        end
        if (sram_rden && !stuck) begin
          pend = 3; pend_rd = 1'b1; pa = sram_addr;
        end
      end
    end
  end

  // One LSU access; lat is the cycle (acceptance edge = 0) in which done is seen.
  task automatic req(input bit wr, input bit rd, input logic [1:0] sz, input bit uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rdata, output logic err,
                     output int nstrobe, output logic [17:0] s_addr,
                     output logic [3:0] s_bmask, output logic [31:0] s_wdata);
    lat = -1; rdata = 'x; err = 1'bx; nstrobe = 0;
    s_addr = 'x; s_bmask = 'x; s_wdata = 'x;
    @(negedge clk);
    lsu_wren = wr; lsu_rden = rd; lsu_size = sz; lsu_unsigned = uns;
    lsu_addr = a; lsu_wdata = wd;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (sram_wren || sram_rden) begin
        nstrobe++;
        s_addr = sram_addr; s_bmask = sram_bmask; s_wdata = sram_wdata;
      end
      if (lsu_done) begin
        lat = c; rdata = lsu_rdata; err = lsu_err;
        break;
      end
    end
    lsu_wren = 1'b0; lsu_rden = 1'b0;
    if (lat < 0) check("done_within_budget", 32'h0, 32'h1);
  endtask

  int          lat, ns;
  logic [31:0] rdata, swd;
  logic        err;
  logic [17:0] sa;
  logic [3:0]  sbm;

  initial begin
    rst_n = 1'b0;
    lsu_addr = '0; lsu_wdata = '0; lsu_wren = 1'b0; lsu_rden = 1'b0;
    lsu_size = 2'b00; lsu_unsigned = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", lsu_busy, 0);
    check("rst_done", lsu_done, 0);
    check("rst_err", lsu_err, 0);
    check("rst_rdata", lsu_rdata, 0);
    check("rst_outs", {sram_addr, sram_bmask, sram_wren, sram_rden}, 0);
    check("rst_wdata", sram_wdata, 0);
    rst_n = 1'b1;

    // sw / lw word round trip
    req(1, 0, 2'b10, 0, 32'h100, 32'h12345678, lat, rdata, err, ns, sa, sbm, swd);
    check("sw_lat", lat, 4);
    check("sw_err", err, 0);
    check("sw_nstrobe", ns, 1);
    check("sw_addr", sa, 18'h080);
    check("sw_bmask", sbm, 4'b1111);
    check("sw_wdata", swd, 32'h12345678);
    req(0, 1, 2'b10, 0, 32'h100, 32'h0, lat, rdata, err, ns, sa, sbm, swd);
    check("lw_lat", lat, 5);
    check("lw_rdata", rdata, 32'h12345678);
    check("lw_err", err, 0);
    check("lw_wdata_zero", swd, 0);

    // byte lane 3: memory word becomes 0xA5345678
    req(1, 0, 2'b00, 0, 32'h103, 32'h000000A5, lat, rdata, err, ns, sa, sbm, swd);
    check("sb_bmask", sbm, 4'b1000);
    check("sb_wdata", swd, 32'hA5A5A5A5);
    check("sb_addr", sa, 18'h080);
    req(0, 1, 2'b00, 0, 32'h103, 32'h0, lat, rdata, err, ns, sa, sbm, swd);
    check("lb_rdata", rdata, 32'hFFFFFFA5);
    req(0, 1, 2'b00, 1, 32'h103, 32'h0, lat, rdata, err, ns, sa, sbm, swd);
    check("lbu_rdata", rdata, 32'h000000A5);
    req(0, 1, 2'b00, 0, 32'h101, 32'h0, lat, rdata, err, ns, sa, sbm, swd);
    check("lb1_rdata", rdata, 32'h00000056);
    check("lb1_bmask", sbm, 4'b0010);

    // upper halfword at 0x106
    req(1, 0, 2'b01, 0, 32'h106, 32'h00008001, lat, rdata, err, ns, sa, sbm, swd);
    check("sh_bmask", sbm, 4'b1100);
    check("sh_addr", sa, 18'h082);
    check("sh_wdata", swd, 32'h80018001);
    req(0, 1, 2'b01, 0, 32'h106, 32'h0, lat, rdata, err, ns, sa, sbm, swd);
    check("lh_rdata", rdata, 32'hFFFF8001);
    req(0, 1, 2'b01, 1, 32'h106, 32'h0, lat, rdata, err, ns, sa, sbm, swd);
    check("lhu_rdata", rdata, 32'h00008001);

    // requests rejected without a controller access
    req(0, 1, 2'b10, 0, 32'h102, 32'h0, lat, rdata, err, ns, sa, sbm, swd);
    check("lw_mis_lat", lat, 1);
    check("lw_mis_err", err, 1);
    check("lw_mis_rdata", rdata, 0);
    check("lw_mis_strobes", ns, 0);
    req(0, 1, 2'b01, 0, 32'h101, 32'h0, lat, rdata, err, ns, sa, sbm, swd);
    check("lh_mis_lat", lat, 1);
    check("lh_mis_err", err, 1);
    check("lh_mis_strobes", ns, 0);
    req(0, 1, 2'b11, 0, 32'h100, 32'h0, lat, rdata, err, ns, sa, sbm, swd);
    check("size3_err", err, 1);
    check("size3_strobes", ns, 0);
    req(1, 1, 2'b10, 0, 32'h100, 32'h55, lat, rdata, err, ns, sa, sbm, swd);
    check("both_lat", lat, 1);
    check("both_err", err, 1);
    check("both_strobes", ns, 0);

    // controller never acknowledges: done 16 cycles after entering S_WAIT (cycle 2)
    stuck = 1'b1;
    req(0, 1, 2'b10, 0, 32'h100, 32'h0, lat, rdata, err, ns, sa, sbm, swd);
    check("tmo_lat", lat, 18);
    check("tmo_err", err, 1);
    check("tmo_rdata", rdata, 0);
    check("tmo_strobes", ns, 1);
    stuck = 1'b0;
    req(0, 1, 2'b10, 0, 32'h100, 32'h0, lat, rdata, err, ns, sa, sbm, swd);
    check("post_tmo_lat", lat, 5);
    check("post_tmo_rdata", rdata, 32'hA5345678);

    // reset while a read is in S_WAIT
    @(negedge clk);
    lsu_rden = 1'b1; lsu_size = 2'b10; lsu_addr = 32'h100; lsu_unsigned = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    lsu_rden = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", lsu_busy, 0);
    check("midrst_outs", {sram_addr, sram_bmask, sram_wren, sram_rden, lsu_done, lsu_err}, 0);
    check("midrst_data", sram_wdata | lsu_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (lsu_done || lsu_busy) seen++;
      end
      check("midrst_no_done", seen, 0);
    end
    req(1, 0, 2'b10, 0, 32'h7FFFC, 32'hCAFEF00D, lat, rdata, err, ns, sa, sbm, swd);
    check("top_sw_lat", lat, 4);
    check("top_sw_addr", sa, 18'h3FFFE);
    req(0, 1, 2'b10, 0, 32'h7FFFC, 32'h0, lat, rdata, err, ns, sa, sbm, swd);
    check("top_lw_rdata", rdata, 32'hCAFEF00D);
    check("top_lw_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
